vlc_adaptive_codeword: RTL and testbench
========================================

Name: vlc_adaptive_codeword

Overview:
- Parametrised successor to the single-order exp-Golomb length unit in the VLC path of the ProRes encoder.
- Implements the full ProRes adaptive codebook: a Rice region for small quotients, an escape into exp-Golomb with a separate order, and an optional trailing sign bit.
- Produces a right-aligned codeword value plus its length, with implicit leading zeros, for the downstream bit packer.
- Three-stage pipeline with valid/ready backpressure on both sides and an overflow flag.

Parameters:
- DATA_W, 16: magnitude width of in_val.
- CODE_W, 32: width of out_code; the maximum codeword length that can be emitted.
- LEN_W, 7: width of out_len; must hold 2*DATA_W+6.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_val  in  DATA_W  unsigned magnitude to encode.
- in_rice_k  in  3  Rice order R.
- in_exp_k  in  3  exp-Golomb order K.
- in_last_q  in  2  last Rice quotient L.
- in_signed  in  1  append a sign bit.
- in_sign  in  1  sign bit value (1 = negative).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_code  out  CODE_W  codeword, right-aligned; leading zeros implicit.
- out_len  out  LEN_W  total codeword length in bits.
- out_err  out  1  length exceeded CODE_W.

Behaviour:
- Reset state: out_valid=0, out_code=0, out_len=0, out_err=0, all stage valids 0. Reset takes effect immediately, mid-flight included; in-flight beats are discarded.
- Handshake:
  - Advance signal: adv = !out_valid | out_ready. in_ready = adv.
  - When adv=1, every stage shifts one step.
  - A beat is accepted when in_valid & in_ready.
  - out_valid and out_code/out_len/out_err hold stable while out_valid & !out_ready.
- Latency: 3 cycles from acceptance to out_valid with out_ready held 1. Throughput is 1 beat/cycle.
- S1: register the inputs. Compute q = in_val >> R and rice = (q <= L).
- S2:
  - Rice region: carry q and the R LSBs of in_val.
  - Exp region: v = val - ((L+1) << R) + (1 << K). Width DATA_W+1; no underflow is possible in this region. n = floor(log2 v), found with a priority encoder.
- S3, compose:
  - Rice: code = (1 << R) | (val & ((1 << R) - 1)); len = q + 1 + R.
  - Exp: code = v; len = (L+1) + 2n - K + 1.
  - If in_signed: code = (code << 1) | sign and len += 1. The sign bit is appended whenever in_signed=1; suppressing it for zero values is the caller's responsibility.
- Overflow: if len > CODE_W, then out_err=1, out_code=0, and out_len = true length. The beat is still emitted; there is no stall.
- Edge cases:
  - R=0: the mask is 0, so code = 1.
  - The log2 of v is always >= K, because v >= (1 << K).
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Test Plan:
- R=2, K=3, L=1, val=5, unsigned -> out_code=5 (0b101), out_len=4, out_err=0, 3 cycles after accept.
- Same codebook, val=8 -> exp region, v=8, n=3 -> out_code=8, out_len=6 (bitstream 001000).
- Same codebook, val=5, in_signed=1, in_sign=1 -> out_code=11 (0b1011), out_len=5. Then R=0, K=0, L=0, val=0 unsigned -> out_code=1, out_len=1.
- Overflow: CODE_W=32, R=0, K=0, L=0, val=0xFFFF, in_signed=1 -> v=0xFFFF, n=15 -> out_len=33, out_err=1, out_code=0. The same input unsigned -> out_len=32, out_err=0, out_code=0xFFFF.
- Backpressure: push 5 back-to-back beats (val=0..4) with out_ready=0 from cycle 0. Required:
  - in_ready drops once the first beat reaches the output.
  - Outputs hold stable while stalled.
  - On release, all 5 beats are emitted in order, with no loss or duplication.
  - Random out_ready toggling gives the same ordering.
- Reset mid-operation: 3 beats in flight, assert reset for 1 cycle -> out_valid=0 immediately, none of the 3 beats appear afterward, and a beat pushed after release emerges 3 cycles later.

Source files
------------

// File: rtl/vlc_adaptive_codeword.sv
// ProRes adaptive VLC codeword generator. It covers the Rice region, the exp-Golomb escape and
// an optional sign bit. The result is a right-aligned codeword plus its length, in three stages.
module vlc_adaptive_codeword #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CODE_W = 32,
    parameter int unsigned LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_val,
    input  logic [2:0]        in_rice_k,
    input  logic [2:0]        in_exp_k,
    input  logic [1:0]        in_last_q,
    input  logic              in_signed,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_err
);
    localparam int unsigned VW = DATA_W + 1;
    localparam int unsigned NW = $clog2(VW);
    localparam int unsigned PW = VW + 1;

    logic adv;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_val_q;
    logic [2:0]        s1_r_q, s1_k_q;
    logic [1:0]        s1_l_q;
    logic              s1_sgn_q, s1_sign_q;

    logic [DATA_W-1:0] s1_quot;
    logic              s1_rice;
    logic [DATA_W-1:0] s1_low_full;
    logic [7:0]        s1_low;
    logic [VW-1:0]     s1_esc;
    logic [VW-1:0]     s1_v;

    logic          s2_valid_q, s2_rice_q;
    logic [1:0]    s2_quot_q;
    logic [7:0]    s2_low_q;
    logic [VW-1:0] s2_v_q;
    logic [2:0]    s2_r_q, s2_k_q;
    logic [1:0]    s2_l_q;
    logic          s2_sgn_q, s2_sign_q;

    logic [NW-1:0]     s2_n;
    logic [7:0]        s2_rice_code;
    logic [PW-1:0]     s2_code;
    logic [LEN_W-1:0]  s2_len;
    logic              s2_err;

    logic              out_valid_q;
    logic [CODE_W-1:0] out_code_q;
    logic [LEN_W-1:0]  out_len_q;
    logic              out_err_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    // Stage 1: registered inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_val_q   <= '0;
            s1_r_q     <= '0;
            s1_k_q     <= '0;
            s1_l_q     <= '0;
            s1_sgn_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_val_q  <= in_val;
                s1_r_q    <= in_rice_k;
                s1_k_q    <= in_exp_k;
                s1_l_q    <= in_last_q;
                s1_sgn_q  <= in_signed;
                s1_sign_q <= in_sign;
            end
        end
    end

    // v only matters in the escape region, where val >= (L+1) << R, so it cannot wrap there
    always_comb begin
        s1_quot     = s1_val_q >> s1_r_q;
        s1_rice     = (s1_quot <= DATA_W'(s1_l_q));
        s1_low_full = s1_val_q & ~({DATA_W{1'b1}} << s1_r_q);
        s1_low      = 8'(s1_low_full);
        s1_esc      = (VW'(s1_l_q) + VW'(1)) << s1_r_q;
        s1_v        = VW'(s1_val_q) - s1_esc + (VW'(1) << s1_k_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_rice_q  <= 1'b0;
            s2_quot_q  <= '0;
            s2_low_q   <= '0;
            s2_v_q     <= '0;
            s2_r_q     <= '0;
            s2_k_q     <= '0;
            s2_l_q     <= '0;
            s2_sgn_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_rice_q <= s1_rice;
                s2_quot_q <= 2'(s1_quot);
                s2_low_q  <= s1_low;
                s2_v_q    <= s1_v;
                s2_r_q    <= s1_r_q;
                s2_k_q    <= s1_k_q;
                s2_l_q    <= s1_l_q;
                s2_sgn_q  <= s1_sgn_q;
                s2_sign_q <= s1_sign_q;
            end
        end
    end

    // Highest set bit of v; never below K because v >= 1 << K in the escape region
    always_comb begin
        s2_n = '0;
        for (int unsigned i = 0; i < VW; i++) begin
            if (s2_v_q[i]) begin
                s2_n = NW'(i);
            end
        end
    end

    always_comb begin
        s2_rice_code = (8'd1 << s2_r_q) | s2_low_q;
        if (s2_rice_q) begin
            s2_code = PW'(s2_rice_code);
            s2_len  = LEN_W'(s2_quot_q) + LEN_W'(1) + LEN_W'(s2_r_q);
        end else begin
            s2_code = PW'(s2_v_q);
            s2_len  = LEN_W'(s2_l_q) + LEN_W'(1) + (LEN_W'(s2_n) << 1)
                      - LEN_W'(s2_k_q) + LEN_W'(1);
        end
        if (s2_sgn_q) begin
            s2_code = {s2_code[PW-2:0], s2_sign_q};
            s2_len  = s2_len + LEN_W'(1);
        end
        s2_err = (s2_len > LEN_W'(CODE_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_code_q <= s2_err ? '0 : CODE_W'(s2_code);
                out_len_q  <= s2_len;
                out_err_q  <= s2_err;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_len   = out_len_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_vlc_adaptive_codeword.sv
// Directed bench for vlc_adaptive_codeword: vector table, backpressure streams and mid-flight reset.
module tb_vlc_adaptive_codeword;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CODE_W = 32;
    localparam int unsigned LEN_W  = 7;
    localparam int NVEC = 13;

    typedef struct {
        logic [DATA_W-1:0] val;
        logic [2:0]        r;
        logic [2:0]        k;
        logic [1:0]        l;
        logic              sg;
        logic              sn;
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
        logic              err;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_val;
    logic [2:0]        in_rice_k;
    logic [2:0]        in_exp_k;
    logic [1:0]        in_last_q;
    logic              in_signed;
    logic              in_sign;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [LEN_W-1:0]  out_len;
    logic              out_err;

    int n_cmp;
    int n_mis;
    vec_t vecs [NVEC];
    logic [CODE_W-1:0] st_code [5];
    logic [LEN_W-1:0]  st_len  [5];

    vlc_adaptive_codeword #(
        .DATA_W(DATA_W),
        .CODE_W(CODE_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_val   (in_val),
        .in_rice_k(in_rice_k),
        .in_exp_k (in_exp_k),
        .in_last_q(in_last_q),
        .in_signed(in_signed),
        .in_sign  (in_sign),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .out_len  (out_len),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_book(input logic [2:0] r, input logic [2:0] k, input logic [1:0] l,
                            input logic sg, input logic sn);
        in_rice_k = r;
        in_exp_k  = k;
        in_last_q = l;
        in_signed = sg;
        in_sign   = sn;
    endtask

    // One beat with out_ready high; output must appear after the third edge counting acceptance
    task automatic send_single(input int idx);
        @(negedge clk);
        set_book(vecs[idx].r, vecs[idx].k, vecs[idx].l, vecs[idx].sg, vecs[idx].sn);
        in_val    = vecs[idx].val;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat1", idx), 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_lat2", idx), 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("vec%0d_code", idx), 64'(out_code), 64'(vecs[idx].code));
        chk($sformatf("vec%0d_len", idx), 64'(out_len), 64'(vecs[idx].len));
        chk($sformatf("vec%0d_err", idx), 64'(out_err), 64'(vecs[idx].err));
    endtask

    // Five beats val=0..4, codebook R=2 K=3 L=1; mode 0 stalls 8 cycles, mode 1 random ready
    task automatic run_stream(input int mode);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [CODE_W-1:0] prev_code = '0;
        logic [LEN_W-1:0]  prev_len = '0;
        set_book(3'd2, 3'd3, 2'd1, 1'b0, 1'b0);
        while (got < 5 && cyc < 200) begin
            @(negedge clk);
            out_ready = (mode == 0) ? (cyc >= 8) : 1'($urandom_range(0, 1));
            in_valid  = (sent < 5);
            in_val    = DATA_W'(sent);
            #1;
            if (prev_stall) begin
                chk($sformatf("m%0d_hold_valid", mode), 64'(out_valid), 64'd1);
                chk($sformatf("m%0d_hold_code", mode), 64'(out_code), 64'(prev_code));
                chk($sformatf("m%0d_hold_len", mode), 64'(out_len), 64'(prev_len));
            end
            if (out_valid && !out_ready) begin
                chk($sformatf("m%0d_bp_in_ready", mode), 64'(in_ready), 64'd0);
                if (mode == 0 && !prev_stall)
                    chk("m0_accepted_before_stall", 64'(sent), 64'd3);
            end
            if (!out_valid)
                chk($sformatf("m%0d_idle_in_ready", mode), 64'(in_ready), 64'd1);
            if (out_valid && out_ready) begin
                chk($sformatf("m%0d_beat%0d_code", mode, got), 64'(out_code), 64'(st_code[got]));
                chk($sformatf("m%0d_beat%0d_len", mode, got), 64'(out_len), 64'(st_len[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev_code  = out_code;
            prev_len   = out_len;
            cyc++;
            @(posedge clk);
        end
        chk($sformatf("m%0d_beats_out", mode), 64'(got), 64'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("m%0d_no_dup", mode), 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_val = '0;
        out_ready = 1'b0;
        set_book(3'd0, 3'd0, 2'd0, 1'b0, 1'b0);

        //            val        R     K     L     sg    sn    code           len    err
        vecs[0]  = '{16'd5,     3'd2, 3'd3, 2'd1, 1'b0, 1'b0, 32'd5,         7'd4,  1'b0};
        vecs[1]  = '{16'd8,     3'd2, 3'd3, 2'd1, 1'b0, 1'b0, 32'd8,         7'd6,  1'b0};
        vecs[2]  = '{16'd5,     3'd2, 3'd3, 2'd1, 1'b1, 1'b1, 32'd11,        7'd5,  1'b0};
        vecs[3]  = '{16'd0,     3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd1,         7'd1,  1'b0};
        vecs[4]  = '{16'hFFFF,  3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 32'd0,         7'd33, 1'b1};
        vecs[5]  = '{16'hFFFF,  3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'hFFFF,      7'd32, 1'b0};
        vecs[6]  = '{16'd9,     3'd2, 3'd3, 2'd1, 1'b1, 1'b0, 32'd18,        7'd7,  1'b0};
        vecs[7]  = '{16'd3,     3'd0, 3'd0, 2'd3, 1'b0, 1'b0, 32'd1,         7'd4,  1'b0};
        vecs[8]  = '{16'd4,     3'd0, 3'd0, 2'd3, 1'b0, 1'b0, 32'd1,         7'd5,  1'b0};
        vecs[9]  = '{16'h01FF,  3'd7, 3'd7, 2'd3, 1'b0, 1'b0, 32'd255,       7'd11, 1'b0};
        vecs[10] = '{16'hFFFF,  3'd7, 3'd7, 2'd3, 1'b0, 1'b0, 32'd65151,     7'd28, 1'b0};
        vecs[11] = '{16'hFFFF,  3'd7, 3'd7, 2'd3, 1'b1, 1'b1, 32'd130303,    7'd29, 1'b0};
        vecs[12] = '{16'h8000,  3'd0, 3'd1, 2'd0, 1'b1, 1'b1, 32'h10003,     7'd32, 1'b0};

        st_code[0] = 32'd4; st_len[0] = 7'd3;
        st_code[1] = 32'd5; st_len[1] = 7'd3;
        st_code[2] = 32'd6; st_len[2] = 7'd3;
        st_code[3] = 32'd7; st_len[3] = 7'd3;
        st_code[4] = 32'd4; st_len[4] = 7'd4;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_code", 64'(out_code), 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) send_single(i);

        run_stream(0);
        run_stream(1);

        // Three beats in flight, then an asynchronous reset pulse
        set_book(3'd2, 3'd3, 2'd1, 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_val   = DATA_W'(9 + i);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rstmid_pre_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_code", 64'(out_code), 64'd0);
        chk("rstmid_len", 64'(out_len), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_val   = 16'd5;
        @(posedge clk);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                seen++;
                chk("rstmid_emit_cycle", 64'(c), 64'd2);
                chk("rstmid_emit_code", 64'(out_code), 64'd5);
                chk("rstmid_emit_len", 64'(out_len), 64'd4);
            end
        end
        chk("rstmid_beats_out", 64'(seen), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
